// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared state encoding, constants and default parameters for the match controller
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_MATCH_END = 3'd4
    } match_state_t;

    localparam logic [2:0] WINNER_NONE = 3'd7;

    localparam int DEF_NUM_PLAYERS      = 2;
    localparam int DEF_HP_W             = 10;
    localparam int DEF_HP_MAX           = 100;
    localparam int DEF_ROUNDS_TO_WIN    = 3;
    localparam int DEF_COUNTDOWN_FRAMES = 180;
    localparam int DEF_ROUND_END_FRAMES = 120;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hp_channel.sv
// rtl/hp_channel.sv - one player's health register: reload, saturating damage, alive flag
module hp_channel
    import match_pkg::*;
#(
    parameter int HP_W   = DEF_HP_W,
    parameter int HP_MAX = DEF_HP_MAX
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            reload,
    input  logic            apply,
    input  logic            hit_valid,
    input  logic [HP_W-1:0] hit_dmg,
    output logic [HP_W-1:0] hp,
    output logic            alive
);

    // Health register; a dead player or a zero-damage hit leaves it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp <= HP_W'(HP_MAX);
        end else if (reload) begin
            hp <= HP_W'(HP_MAX);
        end else if (apply && hit_valid && (hit_dmg != '0) && (hp != '0)) begin
            hp <= (hit_dmg >= hp) ? '0 : hp - hit_dmg;
        end
    end

    assign alive = (hp != '0);

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - round/match sequencing, scoring and frame-timed phases for a fighting game
module match_controller
    import match_pkg::*;
#(
    parameter int NUM_PLAYERS      = DEF_NUM_PLAYERS,
    parameter int HP_W             = DEF_HP_W,
    parameter int HP_MAX           = DEF_HP_MAX,
    parameter int ROUNDS_TO_WIN    = DEF_ROUNDS_TO_WIN,
    parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int ROUND_END_FRAMES = DEF_ROUND_END_FRAMES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_vs,
    input  logic                        start,
    input  logic [NUM_PLAYERS-1:0]      hit_valid,
    input  logic [NUM_PLAYERS*HP_W-1:0] hit_dmg,
    output logic [NUM_PLAYERS*HP_W-1:0] hp,
    output logic [NUM_PLAYERS*HP_W-1:0] hp_pad,
    output logic [NUM_PLAYERS-1:0]      alive,
    output logic [NUM_PLAYERS*4-1:0]    score,
    output logic [3:0]                  round_num,
    output logic [2:0]                  state,
    output logic                        controls_en,
    output logic [2:0]                  winner
);

    localparam int CNT_W = $clog2(max_int(COUNTDOWN_FRAMES, ROUND_END_FRAMES) + 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] RE_LAST = CNT_W'(ROUND_END_FRAMES - 1);

    match_state_t     state_q, state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [3:0]       score_r [NUM_PLAYERS];
    logic             vs_s1, vs_s2, vs_s3, armed, frame_tick;
    logic [1:0]       primed;
    logic             start_match, round_decide, next_round, match_won;
    logic [2:0]       alive_cnt, lone;

    // Vsync synchroniser and edge detect; a level already high at reset release
    // must first be seen low (armed) before any tick is produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_s3      <= 1'b0;
            primed     <= 2'b00;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= frame_vs;
            vs_s2      <= vs_s1;
            vs_s3      <= vs_s2;
            primed     <= {primed[0], 1'b1};
            armed      <= armed | (primed[1] & ~vs_s2);
            frame_tick <= vs_s2 & ~vs_s3 & armed;
        end
    end

    // Survivor count, lone survivor index and match-over detection.
    always_comb begin
        alive_cnt = 3'd0;
        lone      = WINNER_NONE;
        match_won = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            alive_cnt = alive_cnt + 3'(alive[i]);
            if (alive[i]) lone = 3'(i);
            if (score_r[i] == 4'(ROUNDS_TO_WIN)) match_won = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_next;
    end

    // Next-state logic and one-cycle control strobes for the datapath.
    always_comb begin
        state_next   = state_q;
        start_match  = 1'b0;
        round_decide = 1'b0;
        next_round   = 1'b0;
        case (state_q)
            ST_IDLE, ST_MATCH_END: begin
                if (start) begin
                    start_match = 1'b1;
                    state_next  = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (frame_tick && frame_cnt == CD_LAST) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (alive_cnt <= 3'd1) begin
                    round_decide = 1'b1;
                    state_next   = ST_ROUND_END;
                end
            end
            ST_ROUND_END: begin
                if (frame_tick && frame_cnt == RE_LAST) begin
                    if (match_won) begin
                        state_next = ST_MATCH_END;
                    end else begin
                        next_round = 1'b1;
                        state_next = ST_COUNTDOWN;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Scores, round number, winner and the phase frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= 4'd0;
            round_num <= 4'd1;
            winner    <= WINNER_NONE;
            frame_cnt <= '0;
        end else begin
            if (start_match) begin
                for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= 4'd0;
                round_num <= 4'd1;
            end
            if (round_decide) begin
                winner <= (alive_cnt == 3'd1) ? lone : WINNER_NONE;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (alive_cnt == 3'd1 && lone == 3'(i) && score_r[i] != 4'd15)
                        score_r[i] <= score_r[i] + 4'd1;
                end
            end
            if (next_round && winner != WINNER_NONE)
                round_num <= (round_num == 4'd15) ? 4'd1 : round_num + 4'd1;
            if (state_next != state_q)
                frame_cnt <= '0;
            else if (frame_tick && (state_q == ST_COUNTDOWN || state_q == ST_ROUND_END))
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_player
            hp_channel #(.HP_W(HP_W), .HP_MAX(HP_MAX)) u_hp (
                .clk       (clk),
                .reset_n   (reset_n),
                .reload    (start_match | next_round),
                .apply     (state_q == ST_PLAY),
                .hit_valid (hit_valid[g]),
                .hit_dmg   (hit_dmg[g*HP_W +: HP_W]),
                .hp        (hp[g*HP_W +: HP_W]),
                .alive     (alive[g])
            );
            assign hp_pad[g*HP_W +: HP_W] = HP_W'(HP_MAX) - hp[g*HP_W +: HP_W];
            assign score[g*4 +: 4]        = score_r[g];
        end
    endgenerate

    assign state       = state_q;
    assign controls_en = (state_q == ST_PLAY);

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - self-checking bench for match_controller with a behavioural match model
module tb_match_controller;
    import match_pkg::*;

    localparam int NP  = 2;
    localparam int HW  = 10;
    localparam int HM  = 100;
    localparam int RTW = 2;
    localparam int CDF = 3;
    localparam int REF = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               frame_vs = 1'b0;
    logic               start = 1'b0;
    logic [NP-1:0]      hit_valid = '0;
    logic [NP*HW-1:0]   hit_dmg = '0;
    logic [NP*HW-1:0]   hp, hp_pad;
    logic [NP-1:0]      alive;
    logic [NP*4-1:0]    score;
    logic [3:0]         round_num;
    logic [2:0]         state;
    logic               controls_en;
    logic [2:0]         winner;

    match_controller #(
        .NUM_PLAYERS(NP), .HP_W(HW), .HP_MAX(HM), .ROUNDS_TO_WIN(RTW),
        .COUNTDOWN_FRAMES(CDF), .ROUND_END_FRAMES(REF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_vs(frame_vs), .start(start),
        .hit_valid(hit_valid), .hit_dmg(hit_dmg), .hp(hp), .hp_pad(hp_pad),
        .alive(alive), .score(score), .round_num(round_num), .state(state),
        .controls_en(controls_en), .winner(winner)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Behavioural model of the match rules, advanced once per clock.
    int m_state, m_round, m_winner, m_cnt, survivors, who, d;
    int m_hp [NP];
    int m_score [NP];
    bit hist [4];
    bit tk, won;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = ST_IDLE; m_round = 1; m_winner = 7; m_cnt = 0;
            for (int i = 0; i < NP; i++) begin m_hp[i] = HM; m_score[i] = 0; end
            for (int i = 0; i < 4; i++) hist[i] = frame_vs;
        end else begin
            // A vsync rise is acted upon at the fourth clock edge after it.
            tk = hist[2] && !hist[3];
            survivors = 0; who = 7;
            for (int i = 0; i < NP; i++) if (m_hp[i] > 0) begin survivors++; who = i; end
            case (m_state)
                ST_IDLE, ST_MATCH_END: if (start) begin
                    for (int i = 0; i < NP; i++) begin m_hp[i] = HM; m_score[i] = 0; end
                    m_round = 1; m_cnt = 0; m_state = ST_COUNTDOWN;
                end
                ST_COUNTDOWN: if (tk) begin
                    m_cnt++;
                    if (m_cnt == CDF) begin m_cnt = 0; m_state = ST_PLAY; end
                end
                ST_PLAY: begin
                    if (survivors <= 1) begin
                        if (survivors == 1) begin
                            if (m_score[who] < 15) m_score[who]++;
                            m_winner = who;
                        end else m_winner = 7;
                        m_cnt = 0; m_state = ST_ROUND_END;
                    end
                    for (int i = 0; i < NP; i++) begin
                        d = int'(hit_dmg[i*HW +: HW]);
                        if (hit_valid[i] && d > 0 && m_hp[i] > 0)
                            m_hp[i] = (d >= m_hp[i]) ? 0 : m_hp[i] - d;
                    end
                end
                ST_ROUND_END: if (tk) begin
                    m_cnt++;
                    if (m_cnt == REF) begin
                        m_cnt = 0; won = 0;
                        for (int i = 0; i < NP; i++) if (m_score[i] == RTW) won = 1;
                        if (won) m_state = ST_MATCH_END;
                        else begin
                            if (m_winner != 7) m_round = (m_round == 15) ? 1 : m_round + 1;
                            for (int i = 0; i < NP; i++) m_hp[i] = HM;
                            m_state = ST_COUNTDOWN;
                        end
                    end
                end
                default: m_state = ST_IDLE;
            endcase
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = frame_vs;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    bit ok;
    always @(negedge clk) begin
        if (checking && reset_n) begin
            tests++;
            ok = (int'(state) == m_state) && (controls_en == (m_state == ST_PLAY)) &&
                 (int'(round_num) == m_round) && (int'(winner) == m_winner);
            for (int i = 0; i < NP; i++) begin
                if (int'(hp[i*HW +: HW]) != m_hp[i]) ok = 0;
                if (int'(hp_pad[i*HW +: HW]) != HM - m_hp[i]) ok = 0;
                if (alive[i] != (m_hp[i] > 0)) ok = 0;
                if (int'(score[i*4 +: 4]) != m_score[i]) ok = 0;
            end
            if (!ok) begin
                fails++;
                $display("FAIL cycle_model t=%0t got st=%0d hp0=%0d hp1=%0d sc=%h rnd=%0d win=%0d ce=%0b exp st=%0d hp0=%0d hp1=%0d sc0=%0d sc1=%0d rnd=%0d win=%0d",
                         $time, state, hp[HW-1:0], hp[2*HW-1:HW], score, round_num, winner, controls_en,
                         m_state, m_hp[0], m_hp[1], m_score[0], m_score[1], m_round, m_winner);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_vs = 1'b1; cyc(6);
        frame_vs = 1'b0; cyc(6);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic hit(input logic [1:0] v, input int d0, input int d1);
        hit_valid = v;
        hit_dmg   = {HW'(d1), HW'(d0)};
        cyc(1);
        hit_valid = '0;
        hit_dmg   = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1; checking = 1'b1;
        cyc(4);
        check("reset_state", int'(state), ST_IDLE);
        check("reset_hp0", int'(hp[HW-1:0]), 100);
        check("reset_round", int'(round_num), 1);
        check("reset_winner", int'(winner), 7);
        check("reset_ctrl", int'(controls_en), 0);

        pulse_start();
        check("start_countdown", int'(state), ST_COUNTDOWN);
        hit(2'b11, 50, 50);
        check("cd_hit_ignored", int'(hp[HW-1:0]), 100);
        frames(2);
        frame_vs = 1'b1; cyc(3);
        check("cd_before_play", int'(state), ST_COUNTDOWN);
        cyc(1);
        check("play_4th_cycle", int'(state), ST_PLAY);
        check("play_ctrl_en", int'(controls_en), 1);
        frame_vs = 1'b0; cyc(6);

        pulse_start();
        check("start_in_play", int'(state), ST_PLAY);
        hit(2'b10, 0, 30);
        check("hp1_70", int'(hp[2*HW-1:HW]), 70);
        check("pad1_30", int'(hp_pad[2*HW-1:HW]), 30);
        cyc(1);
        hit(2'b10, 0, 80);
        check("hp1_0", int'(hp[2*HW-1:HW]), 0);
        cyc(1);
        check("re_state", int'(state), ST_ROUND_END);
        check("re_alive", int'(alive), 1);
        check("re_score0", int'(score[3:0]), 1);
        check("re_winner", int'(winner), 0);
        frames(REF);
        check("r2_state", int'(state), ST_COUNTDOWN);
        check("r2_round", int'(round_num), 2);
        check("r2_hp1", int'(hp[2*HW-1:HW]), 100);

        frames(CDF);
        hit(2'b11, 200, 200);
        check("draw_hp", int'(hp), 0);
        cyc(1);
        check("draw_winner", int'(winner), 7);
        check("draw_score", int'(score), 1);
        frames(REF);
        check("draw_round", int'(round_num), 2);

        frames(CDF);
        hit(2'b10, 0, 100);
        cyc(1);
        check("m_score0", int'(score[3:0]), 2);
        frames(REF);
        check("match_end", int'(state), ST_MATCH_END);
        frame();
        check("match_end_hold", int'(state), ST_MATCH_END);
        pulse_start();
        check("restart_state", int'(state), ST_COUNTDOWN);
        check("restart_score", int'(score), 0);
        check("restart_round", int'(round_num), 1);

        frames(CDF);
        hit(2'b10, 0, 100);
        cyc(1);
        frames(REF);
        frames(CDF);
        hit(2'b01, 60, 0);
        check("hp0_40", int'(hp[HW-1:0]), 40);
        check("pre_reset_score", int'(score[3:0]), 1);
        reset_n = 1'b0;
        #2;
        check("async_state", int'(state), ST_IDLE);
        check("async_hp0", int'(hp[HW-1:0]), 100);
        check("async_score", int'(score), 0);
        check("async_round", int'(round_num), 1);

        frame_vs = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        pulse_start();
        cyc(10);
        check("vs_high_no_tick", int'(state), ST_COUNTDOWN);
        frame_vs = 1'b0; cyc(6);
        frames(CDF);
        check("play_after_rearm", int'(state), ST_PLAY);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
